// File: rtl/shifter_arbiter.sv
// ============================================================================
// shifter_arbiter / barrel_shifter_4bit : two requesters share one 4-bit rotator
// Revision: 1.0
// ============================================================================
`default_nettype none

module barrel_shifter_4bit (
    input  logic [3:0] data_in,
    input  logic [1:0] amt,
    output logic [3:0] data_out
);
    logic [3:0] stage1;

    assign stage1   = amt[0] ? {data_in[2:0], data_in[3]} : data_in;
    assign data_out = amt[1] ? {stage1[1:0], stage1[3:2]} : stage1;
endmodule

module shifter_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_data,
    input  logic [1:0] req0_amt,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_data,
    input  logic [1:0] req1_amt,
    output logic       req1_ready,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       out_id,
    input  logic       out_ready,
    output logic [7:0] done_cnt
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op_data_q, op_data_d;
    logic [1:0] op_amt_q, op_amt_d;
    logic       op_id_q, op_id_d;
    logic       last_grant_q, last_grant_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] out_data_q, out_data_d;
    logic       out_id_q, out_id_d;
    logic [7:0] done_cnt_q, done_cnt_d;

    logic       grant;
    logic       accept;
    logic [3:0] shift_result;

    // grant is the requester index that would win this cycle
    generate
        if (RR_EN != 0) begin : g_round_robin
            assign grant = (req0_valid && req1_valid) ? ~last_grant_q
                                                      : (req1_valid && !req0_valid);
        end else begin : g_fixed_priority
            assign grant = ~req0_valid;
        end
    endgenerate

    assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state_q == IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;

    barrel_shifter_4bit u_shifter (
        .data_in  (op_data_q),
        .amt      (op_amt_q),
        .data_out (shift_result)
    );

    always_comb begin
        state_d      = state_q;
        op_data_d    = op_data_q;
        op_amt_d     = op_amt_q;
        op_id_d      = op_id_q;
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        done_cnt_d   = done_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_data_d    = grant ? req1_data : req0_data;
                    op_amt_d     = grant ? req1_amt  : req0_amt;
                    op_id_d      = grant;
                    last_grant_d = grant;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                out_data_d  = shift_result;
                out_id_d    = op_id_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_data_q    <= 4'd0;
            op_amt_q     <= 2'd0;
            op_id_q      <= 1'b0;
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= 4'd0;
            out_id_q     <= 1'b0;
            done_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            op_data_q    <= op_data_d;
            op_amt_q     <= op_amt_d;
            op_id_q      <= op_id_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign done_cnt  = done_cnt_q;
endmodule

`default_nettype wire

// File: tb/tb_shifter_arbiter.sv
// ============================================================================
// tb_shifter_arbiter : round-robin and fixed-priority instances share stimulus
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shifter_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, out_ready;
    logic [3:0] req0_data, req1_data;
    logic [1:0] req0_amt, req1_amt;

    logic       rr_req0_ready, rr_req1_ready, rr_out_valid, rr_out_id;
    logic [3:0] rr_out_data;
    logic [7:0] rr_done_cnt;
    logic       fp_req0_ready, fp_req1_ready, fp_out_valid, fp_out_id;
    logic [3:0] fp_out_data;
    logic [7:0] fp_done_cnt;

    int tests  = 0;
    int failed = 0;

    logic       last_rr;
    logic [7:0] exp_cnt;
    logic [3:0] exp_rr_data, exp_fp_data;
    logic       exp_rr_id, exp_fp_id;

    always #5 clk = ~clk;

    shifter_arbiter #(.RR_EN(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt), .req0_ready(rr_req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt), .req1_ready(rr_req1_ready),
        .out_valid(rr_out_valid), .out_data(rr_out_data), .out_id(rr_out_id),
        .out_ready(out_ready), .done_cnt(rr_done_cnt)
    );

    shifter_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt), .req0_ready(fp_req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt), .req1_ready(fp_req1_ready),
        .out_valid(fp_out_valid), .out_data(fp_out_data), .out_id(fp_out_id),
        .out_ready(out_ready), .done_cnt(fp_done_cnt)
    );

    function automatic logic [3:0] rot(input logic [3:0] d, input logic [1:0] a);
        int v = int'(d);
        int s = int'(a);
        return 4'(((v << s) | (v >> (4 - s))) & 15);
    endfunction

    // Arbitration rule: RR alternates on contention, fixed priority favours requester 0
    function automatic logic grant_of(input bit rr, input bit v0, input bit v1, input logic last);
        if (!rr)
            return !v0;
        if (v0 && v1)
            return !last;
        return v1;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        last_rr = 1'b1;
        exp_cnt = 8'd0;
    endtask

    task automatic run_op(input bit v0, input logic [3:0] d0, input logic [1:0] a0,
                          input bit v1, input logic [3:0] d1, input logic [1:0] a1,
                          input int stall);
        logic g_rr, g_fp;
        @(negedge clk);
        req0_valid = v0; req0_data = d0; req0_amt = a0;
        req1_valid = v1; req1_data = d1; req1_amt = a1;
        out_ready  = 1'b1;
        g_rr = grant_of(1'b1, v0, v1, last_rr);
        g_fp = grant_of(1'b0, v0, v1, 1'b0);
        #1;
        check("rr_idle_ready0", 8'(rr_req0_ready), 8'(v0 && !g_rr));
        check("rr_idle_ready1", 8'(rr_req1_ready), 8'(v1 && g_rr));
        check("fp_idle_ready0", 8'(fp_req0_ready), 8'(v0 && !g_fp));
        check("fp_idle_ready1", 8'(fp_req1_ready), 8'(v1 && g_fp));

        @(posedge clk); #1;
        last_rr     = g_rr;
        exp_rr_id   = g_rr;
        exp_rr_data = g_rr ? rot(d1, a1) : rot(d0, a0);
        exp_fp_id   = g_fp;
        exp_fp_data = g_fp ? rot(d1, a1) : rot(d0, a0);
        check("shift_rr_valid", 8'(rr_out_valid), 8'd0);
        check("shift_fp_valid", 8'(fp_out_valid), 8'd0);
        check("shift_rr_readys", 8'({rr_req0_ready, rr_req1_ready}), 8'd0);

        @(posedge clk); #1;
        check("hold_rr_valid", 8'(rr_out_valid), 8'd1);
        check("hold_rr_data", 8'(rr_out_data), 8'(exp_rr_data));
        check("hold_rr_id", 8'(rr_out_id), 8'(exp_rr_id));
        check("hold_fp_valid", 8'(fp_out_valid), 8'd1);
        check("hold_fp_data", 8'(fp_out_data), 8'(exp_fp_data));
        check("hold_fp_id", 8'(fp_out_id), 8'(exp_fp_id));
        check("hold_rr_cnt", rr_done_cnt, exp_cnt);
        check("hold_readys", 8'({rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready}), 8'd0);

        if (stall > 0) begin
            out_ready  = 1'b0;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            repeat (stall) begin
                @(posedge clk); #1;
                check("stall_valid", 8'(rr_out_valid), 8'd1);
                check("stall_data", 8'(rr_out_data), 8'(exp_rr_data));
                check("stall_id", 8'(rr_out_id), 8'(exp_rr_id));
                check("stall_readys", 8'({rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready}), 8'd0);
                check("stall_cnt", rr_done_cnt, exp_cnt);
            end
            out_ready = 1'b1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        @(posedge clk); #1;
        exp_cnt = exp_cnt + 8'd1;
        check("done_rr_valid", 8'(rr_out_valid), 8'd0);
        check("done_fp_valid", 8'(fp_out_valid), 8'd0);
        check("done_rr_cnt", rr_done_cnt, exp_cnt);
        check("done_fp_cnt", fp_done_cnt, exp_cnt);
    endtask

    initial begin
        bit         v0, v1;
        logic [3:0] cnt_before;

        rst_n = 1'b0; out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 4'hF; req0_amt = 2'd1;
        req1_valid = 1'b1; req1_data = 4'hA; req1_amt = 2'd2;
        last_rr = 1'b1; exp_cnt = 8'd0;
        exp_rr_data = 4'd0; exp_fp_data = 4'd0; exp_rr_id = 1'b0; exp_fp_id = 1'b0;
        cnt_before = 4'd0;

        // Reset state, readys held low while reset is asserted
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 8'(rr_out_valid), 8'd0);
        check("rst_out_data", 8'(rr_out_data), 8'd0);
        check("rst_out_id", 8'(rr_out_id), 8'd0);
        check("rst_done_cnt", rr_done_cnt, 8'd0);
        check("rst_readys", 8'({rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready}), 8'd0);
        rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;

        // Single requester, every rotate amount
        for (int a = 0; a < 4; a++)
            run_op(1'b1, 4'b0001, 2'(a), 1'b0, 4'd0, 2'd0, 0);
        check("single_cnt4", rr_done_cnt, 8'd4);

        // Withdrawn request: no acceptance, no output
        @(negedge clk);
        req1_valid = 1'b1; req1_data = 4'h3; req1_amt = 2'd1;
        #1;
        check("withdraw_ready1", 8'(rr_req1_ready), 8'd1);
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("withdraw_valid", 8'(rr_out_valid), 8'd0);
        check("withdraw_cnt", rr_done_cnt, exp_cnt);

        // Contention after reset: req0, then req1, then req0 again
        do_reset();
        run_op(1'b1, 4'b1011, 2'd2, 1'b1, 4'b1000, 2'd1, 0);
        check("cont1_data", 8'(rr_out_data), 8'b1110);
        check("cont1_id", 8'(rr_out_id), 8'd0);
        run_op(1'b1, 4'b1011, 2'd2, 1'b1, 4'b1000, 2'd1, 0);
        check("cont2_data", 8'(rr_out_data), 8'b0001);
        check("cont2_id", 8'(rr_out_id), 8'd1);
        run_op(1'b1, 4'b0110, 2'd3, 1'b1, 4'b1001, 2'd2, 0);
        check("cont3_id", 8'(rr_out_id), 8'd0);
        check("fp_cont3_id", 8'(fp_out_id), 8'd0);

        // Backpressure in HOLD
        run_op(1'b0, 4'd0, 2'd0, 1'b1, 4'b1100, 2'd3, 5);

        // Reset during SHIFT discards the in-flight operation
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 4'b0101; req0_amt = 2'd1; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; req0_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", 8'(rr_out_valid), 8'd0);
        check("midrst_cnt", rr_done_cnt, 8'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("midrst_readys", 8'({rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready}), 8'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1; last_rr = 1'b1; exp_cnt = 8'd0;
        run_op(1'b1, 4'b0011, 2'd3, 1'b1, 4'b0111, 2'd0, 0);
        check("postrst_data", 8'(rr_out_data), 8'b1001);

        // 256 randomized operations wrap the counter back to 0
        do_reset();
        for (int i = 0; i < 256; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            run_op(v0, 4'($urandom), 2'($urandom), v1, 4'($urandom), 2'($urandom),
                   (i % 37 == 5) ? 2 : 0);
        end
        check("wrap_cnt", rr_done_cnt, 8'd0);
        run_op(1'b1, 4'b1000, 2'd1, 1'b1, 4'b0100, 2'd2, 0);
        check("after_wrap_cnt", rr_done_cnt, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

`default_nettype wire
